fdtd_rd_arbiter: RTL and testbench

//   Round-robin arbiter that shares one FDTD word-read AXI master between
//   N_REQ requesters (e.g. E-field and H-field coefficient fetchers).
//   It accepts one word read at a time, forwards it to the master's
//   req/word_addr port and registers the returned word. It then grants
//   the winning requester.

---
 rtl/fdtd_rd_arbiter_if.sv | 29 ++
 rtl/fdtd_rd_arbiter.sv | 89 ++++++++
 tb/tb_fdtd_rd_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdtd_rd_arbiter_if.sv
// Requester-side and AXI-read-master-side signals of the FDTD word-read arbiter.
// Valid/ready: a requester holds req_i[k] and its address until gnt_o[k]; the master side holds mst_req_o until mst_gnt_i.
interface fdtd_rd_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*ADDR_WIDTH-1:0] word_addr_i;
  logic [N_REQ-1:0]            gnt_o;
  logic [DATA_WIDTH-1:0]       data_o;
  logic                        busy_o;
  logic [$clog2(N_REQ)-1:0]    sel_o;
  logic                        mst_req_o;
  logic [ADDR_WIDTH-1:0]       mst_word_addr_o;
  logic [DATA_WIDTH-1:0]       mst_data_i;
  logic                        mst_gnt_i;
  logic [1:0]                  state_o;

  modport slave (
    input  req_i, word_addr_i, mst_data_i, mst_gnt_i,
    output gnt_o, data_o, busy_o, sel_o, mst_req_o, mst_word_addr_o, state_o
  );

  modport master (
    output req_i, word_addr_i, mst_data_i, mst_gnt_i,
    input  gnt_o, data_o, busy_o, sel_o, mst_req_o, mst_word_addr_o, state_o
  );
endinterface

// File: rtl/fdtd_rd_arbiter.sv
// Round-robin arbiter sharing one FDTD word-read AXI master among N_REQ requesters.
// One read in flight at a time: IDLE picks a winner, BUSY waits for the master, RESP pulses the grant.
module fdtd_rd_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  fdtd_rd_arbiter_if.slave   bus
);
  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      r_last;
  logic [SEL_W-1:0]      w_win;
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  // Scan from last+1 with wrap; iterating downward lets the nearest requester win.
  always_comb begin
    w_any = |bus.req_i;
    w_win = r_last;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req_i[(int'(r_last) + i) % N_REQ]) begin
        w_win = SEL_W'((int'(r_last) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (bus.mst_gnt_i) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_sel  <= '0;
      r_last <= SEL_W'(N_REQ - 1);
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_sel  <= w_win;
        r_last <= w_win;
        r_addr <= bus.word_addr_i[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (r_state == S_BUSY && bus.mst_gnt_i) begin
        r_data <= bus.mst_data_i;
      end
    end
  end

  // Outputs decode the registered state, so mst_req_o drops the cycle after mst_gnt_i.
  always_comb begin
    bus.gnt_o           = '0;
    bus.mst_req_o       = (r_state == S_BUSY);
    bus.busy_o          = (r_state != S_IDLE);
    bus.sel_o           = r_sel;
    bus.data_o          = r_data;
    bus.mst_word_addr_o = r_addr;
    bus.state_o         = r_state;
    if (r_state == S_RESP) begin
      bus.gnt_o[r_sel] = 1'b1;
    end
  end
endmodule

// File: tb/tb_fdtd_rd_arbiter.sv
// Bench for fdtd_rd_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level round-robin model and a grant scoreboard.
module tb_fdtd_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = $clog2(N);

  logic ACLK;
  logic ARESETn;

  fdtd_rd_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fdtd_rd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // stimulus controls
  logic [N-1:0]  hold_mask;
  logic [AW-1:0] haddr [N];
  bit            rnd_mode;
  bit            stop_new;
  int            rsp_delay;
  bit            fix_en;
  logic [DW-1:0] fix_data;
  bit            force_gnt;
  logic [DW-1:0] last_rsp_data;
  logic [N-1:0]  seen_gnt;

  // observation records
  int            cyc;
  int            gnt_cnt;
  int            mreq_rise_cyc;
  bit            prev_mreq;
  int            g_idx_q [$];
  int            g_cyc_q [$];
  logic [N-1:0]  g_vec_q [$];
  logic [DW-1:0] g_data_q [$];
  logic [AW-1:0] g_addr_q [$];
  logic          g_mreq_q [$];
  logic [SW+DW-1:0] exp_q [$];

  // reference model: one outstanding read, round-robin pointer
  bit            m_txn;
  bit            m_resp;
  int            m_owner;
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            found;
  int            gi;
  logic [N-1:0]  ev;
  logic [SW+DW-1:0] sb;

  task automatic model_reset();
    m_txn   = 0;
    m_resp  = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_addr  = '0;
    m_data  = '0;
    exp_q.delete();
  endtask

  always @(negedge ACLK) begin
    cyc++;
    if (!ARESETn) begin
      check("rst_mst_req", bus.mst_req_o, 0);
      check("rst_gnt", bus.gnt_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_data", bus.data_o, 0);
      check("rst_sel", bus.sel_o, 0);
      check("rst_addr", bus.mst_word_addr_o, 0);
      model_reset();
    end else begin
      ev = '0;
      if (m_resp) ev[m_owner] = 1'b1;
      check("cyc_mst_req", bus.mst_req_o, m_txn);
      check("cyc_gnt", bus.gnt_o, ev);
      check("cyc_busy", bus.busy_o, m_txn || m_resp);
      check("cyc_sel", bus.sel_o, m_owner);
      check("cyc_data", bus.data_o, m_data);
      check("cyc_addr", bus.mst_word_addr_o, m_addr);
      if (bus.mst_req_o && !prev_mreq) mreq_rise_cyc = cyc;
      if (bus.gnt_o != '0) begin
        gi = 0;
        for (int k = 0; k < N; k++) if (bus.gnt_o[k]) gi = k;
        g_idx_q.push_back(gi);
        g_cyc_q.push_back(cyc);
        g_vec_q.push_back(bus.gnt_o);
        g_data_q.push_back(bus.data_o);
        g_addr_q.push_back(bus.mst_word_addr_o);
        g_mreq_q.push_back(bus.mst_req_o);
        seen_gnt = seen_gnt | bus.gnt_o;
        gnt_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_gnt", 1, 0);
        end else begin
          sb = exp_q.pop_front();
          check("sb_grant", {SW'(gi), bus.data_o}, sb);
        end
      end
      if (m_resp) begin
        m_resp = 0;
      end else if (m_txn) begin
        if (bus.mst_gnt_i) begin
          m_data = bus.mst_data_i;
          exp_q.push_back({SW'(m_owner), bus.mst_data_i});
          m_txn  = 0;
          m_resp = 1;
        end
      end else if (bus.req_i != '0) begin
        found = 0;
        for (int j = 1; j <= N; j++) begin
          if (!found && bus.req_i[(m_last + j) % N]) begin
            m_owner = (m_last + j) % N;
            found = 1;
          end
        end
        m_last = m_owner;
        m_addr = bus.word_addr_i[m_owner*AW +: AW];
        m_txn  = 1;
      end
    end
    prev_mreq = bus.mst_req_o;
  end

  // AXI read master stand-in: answers mst_req_o after a fixed or random delay
  int cnt;
  int cur_delay;
  initial begin
    bus.mst_gnt_i  = 1'b0;
    bus.mst_data_i = '0;
    cnt = 0;
    cur_delay = -1;
    forever begin
      @(posedge ACLK);
      #1;
      bus.mst_gnt_i  = 1'b0;
      bus.mst_data_i = DW'($urandom);
      if (force_gnt) begin
        bus.mst_gnt_i = 1'b1;
        force_gnt = 0;
      end else if (bus.mst_req_o) begin
        if (cur_delay < 0) cur_delay = (rsp_delay < 0) ? int'($urandom_range(0, 4)) : rsp_delay;
        if (cnt == cur_delay) begin
          bus.mst_gnt_i  = 1'b1;
          bus.mst_data_i = fix_en ? fix_data : DW'($urandom);
          last_rsp_data  = bus.mst_data_i;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        cur_delay = -1;
      end
    end
  end

  // requester driver
  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (rnd_mode) begin
        if (seen_gnt[k]) begin
          if (!stop_new && $urandom_range(0, 1) == 1) begin
            bus.word_addr_i[k*AW +: AW] = AW'($urandom);
          end else begin
            bus.req_i[k] = 1'b0;
          end
        end else if (!bus.req_i[k] && !stop_new && $urandom_range(0, 3) == 0) begin
          bus.req_i[k] = 1'b1;
          bus.word_addr_i[k*AW +: AW] = AW'($urandom);
        end
      end else begin
        bus.req_i[k] = hold_mask[k];
        bus.word_addr_i[k*AW +: AW] = haddr[k];
      end
    end
    seen_gnt = '0;
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    drive_reqs();
    @(negedge ACLK);
    #1;
  endtask

  task automatic clear_obs();
    g_idx_q.delete();
    g_cyc_q.delete();
    g_vec_q.delete();
    g_data_q.delete();
    g_addr_q.delete();
    g_mreq_q.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int start;
    bit done;
    start = gnt_cnt;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (gnt_cnt - start >= n) done = 1;
    end
    if (!done) check(name, gnt_cnt - start, n);
  endtask

  task automatic do_reset();
    hold_mask = '0;
    ARESETn = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
  endtask

  int t0;
  int seq3 [6] = '{0, 1, 0, 1, 0, 1};
  int seq4 [4] = '{3, 1, 3, 1};
  int n6;
  int n7;
  bit drained;

  initial begin
    ARESETn   = 1'b0;
    bus.req_i = '0;
    bus.word_addr_i = '0;
    hold_mask = '0;
    for (int k = 0; k < N; k++) haddr[k] = '0;
    rnd_mode  = 0;
    stop_new  = 0;
    rsp_delay = -1;
    fix_en    = 0;
    fix_data  = '0;
    force_gnt = 0;
    seen_gnt  = '0;
    last_rsp_data = '0;
    cyc = 0;
    gnt_cnt = 0;
    mreq_rise_cyc = 0;
    prev_mreq = 0;
    model_reset();
    #1;
    step();
    step();
    ARESETn = 1'b1;
    check("reset_busy", bus.busy_o, 0);
    check("reset_sel", bus.sel_o, 0);

    // single read from requester 0, master answers 3 cycles after mst_req_o
    fix_en = 1;
    fix_data = 32'hDEADBEEF;
    rsp_delay = 3;
    haddr[0] = 30'h100;
    hold_mask = 4'b0001;
    clear_obs();
    step();
    t0 = cyc;
    wait_grants(1, 40, "t1_timeout");
    hold_mask = '0;
    if (g_idx_q.size() >= 1) begin
      check("t1_gnt_vec", g_vec_q[0], 4'b0001);
      check("t1_data", g_data_q[0], 32'hDEADBEEF);
      check("t1_addr", g_addr_q[0], 30'h100);
      check("t1_mst_req_low", g_mreq_q[0], 0);
      check("t1_mreq_latency", mreq_rise_cyc, t0 + 1);
      check("t1_gnt_latency", g_cyc_q[0], t0 + 5);
    end
    step();
    check("t1_gnt_one_cycle", bus.gnt_o, 0);
    fix_en = 0;
    rsp_delay = -1;

    // two requesters held high after reset
    do_reset();
    haddr[0] = 30'h10;
    haddr[1] = 30'h20;
    clear_obs();
    hold_mask = 4'b0011;
    wait_grants(2, 40, "t2_timeout");
    if (g_idx_q.size() >= 2) begin
      check("t2_first", g_idx_q[0], 0);
      check("t2_second", g_idx_q[1], 1);
      check("t2_addr0", g_addr_q[0], 30'h10);
      check("t2_addr1", g_addr_q[1], 30'h20);
    end

    // continuous re-requests alternate
    clear_obs();
    wait_grants(6, 100, "t3_timeout");
    for (int i = 0; i < 6; i++)
      if (i < g_idx_q.size()) check($sformatf("t3_seq%0d", i), g_idx_q[i], seq3[i]);

    // requesters 1 and 3 after requester 1 last won
    hold_mask = '0;
    step();
    step();
    haddr[3] = 30'h30;
    clear_obs();
    hold_mask = 4'b1010;
    wait_grants(4, 80, "t4_timeout");
    for (int i = 0; i < 4; i++)
      if (i < g_idx_q.size()) check($sformatf("t4_seq%0d", i), g_idx_q[i], seq4[i]);
    hold_mask = '0;
    step();
    step();

    // reset while the master is still working on a read
    rsp_delay = 20;
    hold_mask = 4'b0001;
    drained = 0;
    for (int i = 0; i < 10 && !drained; i++) begin
      step();
      if (bus.mst_req_o) drained = 1;
    end
    check("t5_reached_busy", drained, 1);
    step();
    step();
    @(posedge ACLK);
    #3;
    ARESETn = 1'b0;
    #1;
    check("t5_async_mst_req", bus.mst_req_o, 0);
    check("t5_async_gnt", bus.gnt_o, 0);
    check("t5_async_busy", bus.busy_o, 0);
    hold_mask = '0;
    step();
    step();
    ARESETn = 1'b1;
    rsp_delay = -1;
    clear_obs();
    hold_mask = 4'b0010;
    wait_grants(1, 40, "t5_timeout");
    if (g_idx_q.size() >= 1) check("t5_winner", g_idx_q[0], 1);
    hold_mask = '0;
    step();
    step();

    // spurious master grant while idle
    n6 = gnt_cnt;
    force_gnt = 1;
    for (int i = 0; i < 4; i++) step();
    check("t6_no_gnt", gnt_cnt, n6);
    check("t6_data_kept", bus.data_o, last_rsp_data);
    check("t6_idle", bus.busy_o, 0);

    // random traffic
    do_reset();
    n7 = gnt_cnt;
    rnd_mode = 1;
    for (int i = 0; i < 800; i++) step();
    stop_new = 1;
    drained = 0;
    for (int i = 0; i < 300 && !drained; i++) begin
      step();
      if (bus.req_i == '0 && !bus.busy_o) drained = 1;
    end
    check("t7_drain", drained, 1);
    check("t7_progress", (gnt_cnt - n7) > 40, 1);
    check("t7_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
